// File: rtl/pls_kbd_latch_if.sv
// 6502 I/O bus port of the keyboard latch: access strobe, address and
// direction from the CPU side, registered read data back.
interface pls_kbd_latch_if;
  logic        bus_en;
  logic [15:0] bus_addr;
  logic        bus_rw;
  logic [7:0]  rdata;
  logic        rdata_valid;

  modport master (
    output bus_en, bus_addr, bus_rw,
    input  rdata, rdata_valid
  );

  modport slave (
    input  bus_en, bus_addr, bus_rw,
    output rdata, rdata_valid
  );
endinterface

// File: rtl/pls_kbd_latch.sv
// Apple II keyboard latch fed from the Nios keycode port: edge-detects key
// presses, adds auto-repeat, queues events in a small FIFO and presents them
// as the $C000 data/strobe and $C010 strobe-clear registers.
module pls_kbd_latch #(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned REPEAT_DELAY = 25000000,
  parameter int unsigned REPEAT_RATE  = 5000000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [7:0]            keycode_in,
  pls_kbd_latch_if.slave        bus,
  output logic                  key_down,
  output logic                  fifo_ovf,
  input  logic                  ovf_clr
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [31:0] DLY_LAST  = 32'(REPEAT_DELAY - 1);
  localparam logic [31:0] RATE_LAST = 32'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DELAY,
    ST_RATE
  } rpt_state_t;

  logic [7:0]  kc_q;
  logic [7:0]  prev;
  rpt_state_t  state, state_d;
  logic [31:0] cnt, cnt_d;
  logic        rpt_push;
  logic        press;
  logic        key_rel;

  logic [6:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        full, empty;
  logic        push, pop, accept, drop;

  logic        strobe;
  logic [6:0]  latch;
  logic        sel_lo, sel_hi, clr;
  logic        unused_addr_bits;

  assign press   = (kc_q != 8'h00) && (kc_q != prev);
  assign key_rel = (kc_q == 8'h00);

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign sel_lo = bus.bus_en && (bus.bus_addr[15:4] == 12'hC00);
  assign sel_hi = bus.bus_en && (bus.bus_addr[15:4] == 12'hC01);
  assign clr    = sel_hi;
  assign unused_addr_bits = ^bus.bus_addr[3:0];

  // A strobe clear blocks the load this cycle; the load retries next cycle.
  assign pop    = !strobe && !empty && !clr;
  assign push   = press || rpt_push;
  // Pop frees a slot before the push is judged, so full+pop+push never drops.
  assign accept = push && (!full || pop);
  assign drop   = push && full && !pop;

  // Input stage: register the keycode and keep the previous sample for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      kc_q     <= '0;
      prev     <= '0;
      key_down <= 1'b0;
    end else begin
      kc_q     <= keycode_in;
      prev     <= kc_q;
      key_down <= (keycode_in != 8'h00);
    end
  end

  // Repeat FSM state and timer registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // Repeat FSM next state: release and new press override the timer.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    rpt_push = 1'b0;
    if (key_rel) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (press) begin
      state_d = ST_DELAY;
      cnt_d   = '0;
    end else begin
      case (state)
        ST_DELAY: begin
          if (cnt == DLY_LAST) begin
            rpt_push = 1'b1;
            state_d  = ST_RATE;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt + 32'd1;
          end
        end
        ST_RATE: begin
          if (cnt == RATE_LAST) begin
            rpt_push = 1'b1;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt + 32'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Key-event FIFO storage and pointers (extra MSB distinguishes full from empty).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (pop) rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
      if (accept) begin
        mem[wr_ptr[AW-1:0]] <= kc_q[6:0];
        wr_ptr              <= wr_ptr + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  // Sticky overflow flag; a drop in the same cycle beats the clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     fifo_ovf <= 1'b0;
    else if (drop)    fifo_ovf <= 1'b1;
    else if (ovf_clr) fifo_ovf <= 1'b0;
  end

  // Keyboard latch and strobe: load from the FIFO head, clear via $C01x.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      strobe <= 1'b0;
      latch  <= '0;
    end else if (clr) begin
      strobe <= 1'b0;
    end else if (pop) begin
      strobe <= 1'b1;
      latch  <= mem[rd_ptr[AW-1:0]];
    end
  end

  // Registered read port for $C00x (strobe+data) and $C01x (key_down+data).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.rdata       <= '0;
      bus.rdata_valid <= 1'b0;
    end else begin
      bus.rdata_valid <= (sel_lo || sel_hi) && bus.bus_rw;
      if (sel_lo && bus.bus_rw)      bus.rdata <= {strobe, latch};
      else if (sel_hi && bus.bus_rw) bus.rdata <= {key_down, latch};
    end
  end

endmodule

// File: tb/tb_pls_kbd_latch.sv
// Bench for pls_kbd_latch: constant-expectation vectors, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_pls_kbd_latch;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned DLY   = 10;
  localparam int unsigned RATE  = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] keycode_in;
  logic       key_down;
  logic       fifo_ovf;
  logic       ovf_clr;

  always #5 clk = ~clk;

  pls_kbd_latch_if bif();

  pls_kbd_latch #(
    .FIFO_DEPTH  (DEPTH),
    .REPEAT_DELAY(DLY),
    .REPEAT_RATE (RATE)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .keycode_in(keycode_in),
    .bus       (bif.slave),
    .key_down  (key_down),
    .fifo_ovf  (fifo_ovf),
    .ovf_clr   (ovf_clr)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: keys held as an age since press, events in a queue.
  logic [7:0] m_kc_q, m_prev;
  int         m_age;
  logic [6:0] mq[$];
  logic       m_strobe;
  logic [6:0] m_latch;
  logic [7:0] m_rdata;
  logic       m_valid, m_kd, m_ovf;

  typedef struct {
    logic [7:0]  kc;
    logic        en;
    logic [15:0] addr;
    logic        rw;
    logic        oc;
    logic        exp_valid;
    logic        chk_rdata;
    logic [7:0]  exp_rdata;
    logic        exp_kd;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_kc_q = '0; m_prev = '0; m_age = -1; mq.delete();
    m_strobe = 1'b0; m_latch = '0; m_rdata = '0;
    m_valid = 1'b0; m_kd = 1'b0; m_ovf = 1'b0;
  endtask

  task automatic model_step();
    logic       ev, lo, hi, pop, drop;
    logic [6:0] head;
    ev = 1'b0; drop = 1'b0; head = '0;
    if (m_kc_q == 8'h00) m_age = -1;
    else if (m_kc_q != m_prev) begin m_age = 0; ev = 1'b1; end
    else if (m_age >= 0) begin
      m_age++;
      ev = (m_age >= int'(DLY)) && (((m_age - int'(DLY)) % int'(RATE)) == 0);
    end
    lo  = bif.bus_en && (bif.bus_addr >= 16'hC000) && (bif.bus_addr <= 16'hC00F);
    hi  = bif.bus_en && (bif.bus_addr >= 16'hC010) && (bif.bus_addr <= 16'hC01F);
    pop = !m_strobe && (mq.size() != 0) && !hi;
    if (pop) head = mq.pop_front();
    if (ev) begin
      if (mq.size() < DEPTH) mq.push_back(m_kc_q[6:0]);
      else drop = 1'b1;
    end
    m_valid = (lo || hi) && bif.bus_rw;
    if (lo && bif.bus_rw) m_rdata = {m_strobe, m_latch};
    else if (hi && bif.bus_rw) m_rdata = {m_kd, m_latch};
    if (hi) m_strobe = 1'b0;
    else if (pop) begin m_strobe = 1'b1; m_latch = head; end
    if (drop) m_ovf = 1'b1;
    else if (ovf_clr) m_ovf = 1'b0;
    m_kd   = (keycode_in != 8'h00);
    m_prev = m_kc_q;
    m_kc_q = keycode_in;
  endtask

  task automatic drive(input logic [7:0] kc, input logic en, input logic [15:0] addr,
                       input logic rw, input logic oc);
    keycode_in = kc; bif.bus_en = en; bif.bus_addr = addr; bif.bus_rw = rw; ovf_clr = oc;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("rdata", 32'(bif.rdata), 32'(m_rdata));
    check("rdata_valid", 32'(bif.rdata_valid), 32'(m_valid));
    check("key_down", 32'(key_down), 32'(m_kd));
    check("fifo_ovf", 32'(fifo_ovf), 32'(m_ovf));
  endtask

  task automatic idle(input logic [7:0] kc);
    drive(kc, 1'b0, 16'h0000, 1'b1, 1'b0); tick();
  endtask

  task automatic rd(input logic [7:0] kc, input logic [15:0] addr);
    drive(kc, 1'b1, addr, 1'b1, 1'b0); tick();
  endtask

  task automatic wr(input logic [7:0] kc, input logic [15:0] addr);
    drive(kc, 1'b1, addr, 1'b0, 1'b0); tick();
  endtask

  // Asynchronous reset asserted between clock edges, released after one edge.
  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check("rst_rdata", 32'(bif.rdata), 32'h0);
    check("rst_valid", 32'(bif.rdata_valid), 32'h0);
    check("rst_key_down", 32'(key_down), 32'h0);
    check("rst_ovf", 32'(fifo_ovf), 32'h0);
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    logic [15:0] addrs[7];
    logic [7:0]  kcs[5];
    logic [7:0]  kc;
    int          loads;
    logic        pending;

    addrs = '{16'hC000, 16'hC00F, 16'hC010, 16'hC01F, 16'hC020, 16'hBFFF, 16'h0000};
    kcs   = '{8'h00, 8'h41, 8'h42, 8'hC3, 8'h00};

    //          kc     en    addr      rw    oc    vld   chk   rdata  kd    ovf
    vecs[0]  = '{8'hC1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[1]  = '{8'hC1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2]  = '{8'hC1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[3]  = '{8'hC1, 1'b1, 16'hC000, 1'b1, 1'b0, 1'b1, 1'b1, 8'hC1, 1'b1, 1'b0};
    vecs[4]  = '{8'hC1, 1'b1, 16'hC010, 1'b1, 1'b0, 1'b1, 1'b1, 8'hC1, 1'b1, 1'b0};
    vecs[5]  = '{8'hC1, 1'b1, 16'hC000, 1'b1, 1'b0, 1'b1, 1'b1, 8'h41, 1'b1, 1'b0};
    vecs[6]  = '{8'hC1, 1'b1, 16'hC000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[7]  = '{8'hC1, 1'b1, 16'hD000, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[8]  = '{8'h00, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[9]  = '{8'h00, 1'b1, 16'hC000, 1'b1, 1'b0, 1'b1, 1'b1, 8'h41, 1'b0, 1'b0};
    vecs[10] = '{8'h00, 1'b1, 16'hC010, 1'b1, 1'b0, 1'b1, 1'b1, 8'h41, 1'b0, 1'b0};
    vecs[11] = '{8'h00, 1'b1, 16'hC00F, 1'b1, 1'b0, 1'b1, 1'b1, 8'h41, 1'b0, 1'b0};

    reset_n = 1'b0;
    drive(8'h00, 1'b0, 16'h0000, 1'b1, 1'b0);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_rdata", 32'(bif.rdata), 32'h0);
    check("reset_valid", 32'(bif.rdata_valid), 32'h0);
    check("reset_key_down", 32'(key_down), 32'h0);
    check("reset_ovf", 32'(fifo_ovf), 32'h0);
    reset_n = 1'b1;

    // Basic read path, strobe clear, key_down bit, ignored accesses.
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].kc, vecs[i].en, vecs[i].addr, vecs[i].rw, vecs[i].oc);
      tick();
      check($sformatf("vec%0d_valid", i), 32'(bif.rdata_valid), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_key_down", i), 32'(key_down), 32'(vecs[i].exp_kd));
      check($sformatf("vec%0d_ovf", i), 32'(fifo_ovf), 32'(vecs[i].exp_ovf));
      if (vecs[i].chk_rdata)
        check($sformatf("vec%0d_rdata", i), 32'(bif.rdata), 32'(vecs[i].exp_rdata));
    end

    // Three queued keys drained through successive strobe clears.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      idle(8'h41 + 8'(i));
      idle(8'h41 + 8'(i));
    end
    repeat (3) idle(8'h00);
    for (int i = 0; i < 3; i++) begin
      rd(8'h00, 16'hC000);
      check($sformatf("queue_read%0d", i), 32'(bif.rdata), 32'(8'hC1 + 8'(i)));
      wr(8'h00, 16'hC010);
      idle(8'h00);
    end

    // Fill FIFO, overflow, clear, drop-beats-clear, full push+pop.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      idle(8'h41 + 8'(i));
      idle(8'h41 + 8'(i));
    end
    repeat (3) idle(8'h00);
    check("full_no_ovf", 32'(fifo_ovf), 32'h0);
    idle(8'h46); idle(8'h46); idle(8'h00); idle(8'h00);
    check("sixth_ovf", 32'(fifo_ovf), 32'h1);
    drive(8'h00, 1'b0, 16'h0000, 1'b1, 1'b1); tick();
    check("ovf_clr", 32'(fifo_ovf), 32'h0);
    idle(8'h47);
    drive(8'h47, 1'b0, 16'h0000, 1'b1, 1'b1); tick();
    check("ovf_clr_vs_drop", 32'(fifo_ovf), 32'h1);
    idle(8'h00);
    drive(8'h00, 1'b0, 16'h0000, 1'b1, 1'b1); tick();
    wr(8'h48, 16'hC010);
    idle(8'h48);
    check("full_push_pop_no_ovf", 32'(fifo_ovf), 32'h0);
    rd(8'h00, 16'hC000);
    check("full_push_pop_latch", 32'(bif.rdata), 32'hC2);
    for (int i = 0; i < 12; i++) begin
      if (i % 3 == 0) wr(8'h00, 16'hC010);
      else rd(8'h00, 16'hC000);
    end

    // Auto-repeat: hold 30 cycles, poll $C000 and clear on each key seen.
    do_reset();
    loads = 0;
    pending = 1'b0;
    for (int i = 0; i < 45; i++) begin
      kc = (i < 30) ? 8'h41 : 8'h00;
      if (pending) begin
        wr(kc, 16'hC010);
        pending = 1'b0;
      end else begin
        rd(kc, 16'hC000);
        if (bif.rdata[7]) begin
          loads++;
          pending = 1'b1;
        end
      end
    end
    check("repeat_event_count", 32'(loads), 32'd6);

    // Strobe clear in the cycle the FIFO would load the latch.
    do_reset();
    idle(8'h41); idle(8'h41);
    wr(8'h41, 16'hC010);
    rd(8'h41, 16'hC000);
    check("clear_wins", 32'(bif.rdata), 32'h00);
    rd(8'h00, 16'hC000);
    check("load_after_clear", 32'(bif.rdata), 32'hC1);
    idle(8'h00);

    // Reset with queued keys while keycode is held nonzero.
    do_reset();
    idle(8'h42); idle(8'h42); idle(8'h43); idle(8'h43);
    idle(8'h44); idle(8'h44); idle(8'h41); idle(8'h41);
    do_reset();
    rd(8'h41, 16'hC000);
    check("post_reset_empty", 32'(bif.rdata), 32'h00);
    idle(8'h41); idle(8'h41);
    rd(8'h41, 16'hC000);
    check("post_reset_press", 32'(bif.rdata), 32'hC1);
    wr(8'h41, 16'hC010);
    idle(8'h41); idle(8'h41);
    rd(8'h00, 16'hC000);
    check("post_reset_single", 32'(bif.rdata), 32'h41);

    // Randomized traffic against the model, with occasional async resets.
    do_reset();
    kc = 8'h00;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) kc = kcs[$urandom_range(0, 4)];
      if ($urandom_range(0, 4) == 0)
        drive(kc, 1'b0, 16'h0000, 1'b1, ($urandom_range(0, 15) == 0));
      else
        drive(kc, 1'b1, addrs[$urandom_range(0, 6)], 1'($urandom_range(0, 1)),
              ($urandom_range(0, 15) == 0));
      tick();
      if (i % 997 == 996) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
